// File: rtl/srl32_fifo_ctrl_if.sv
// Streaming handshake bundle for the SRL FIFO controller: the upstream (s_*)
// side and the downstream (m_*) side share one interface instance.
interface srl32_fifo_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  // Environment view: produces upstream data and consumes the output register.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  // FIFO controller view.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/srl32_fifo_ctrl.sv
// Controller for a FIFO held in an external bank of addressable shift registers
// (newest entry at index 0), with one registered output stage.
module srl32_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AFULL_LVL = 28
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  srl32_fifo_ctrl_if.slave bus,
  output logic             srl_ce_o,
  output logic [WIDTH-1:0] srl_d_o,
  output logic [4:0]       srl_a_o,
  input  logic [WIDTH-1:0] srl_q_i,
  output logic [5:0]       count_o,
  output logic             almost_full_o
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);
  localparam logic [5:0] AFULL_C = 6'(AFULL_LVL);

  typedef enum logic {
    OEMPTY = 1'b0,
    OFULL  = 1'b1
  } ostate_e;

  ostate_e          ostate_q;
  logic [5:0]       srl_cnt_q;
  logic [5:0]       srl_cnt_d;
  logic [5:0]       srl_cnt_m1;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid;
  logic             s_ready;
  logic             push;
  logic             load;

  assign m_valid = (ostate_q == OFULL);
  // Space is judged on the SRL alone, so a same-edge load never frees a slot early.
  assign s_ready = (srl_cnt_q < DEPTH_C);
  assign push    = bus.s_valid & s_ready;
  assign load    = (srl_cnt_q != 6'd0) & (~m_valid | bus.m_ready);

  assign srl_cnt_m1 = srl_cnt_q - 6'd1;

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = m_data_q;
  assign srl_ce_o      = push;
  assign srl_d_o       = bus.s_data;
  // Oldest entry sits at the highest occupied index.
  assign srl_a_o       = (srl_cnt_q != 6'd0) ? srl_cnt_m1[4:0] : 5'd0;
  assign count_o       = srl_cnt_q + {5'd0, m_valid};
  assign almost_full_o = (srl_cnt_q >= AFULL_C);

  always_comb begin
    srl_cnt_d = srl_cnt_q;
    if (flush_i) begin
      srl_cnt_d = 6'd0;
    end else begin
      srl_cnt_d = srl_cnt_q + {5'd0, push} - {5'd0, load};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      srl_cnt_q <= 6'd0;
      ostate_q  <= OEMPTY;
      m_data_q  <= '0;
    end else begin
      srl_cnt_q <= srl_cnt_d;
      if (flush_i) begin
        ostate_q <= OEMPTY;
      end else begin
        case (ostate_q)
          OEMPTY: begin
            if (load) begin
              ostate_q <= OFULL;
              m_data_q <= srl_q_i;
            end
          end
          OFULL: begin
            if (load) begin
              m_data_q <= srl_q_i;
            end else if (bus.m_ready) begin
              ostate_q <= OEMPTY;
            end
          end
          default: ostate_q <= OEMPTY;
        endcase
      end
    end
  end

endmodule
